regfile_param: RTL and testbench

Parametrised multi-read-port register file with asynchronous reset, a hardwired zero register and an integrated pending-write scoreboard. It is the next-generation register file for the pipelined ARM-64 datapath.
- Decode reserves a destination register.
- Writeback writes it and releases the reservation.
- Per-port busy flags let the hazard unit stall on read-after-write.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_param.sv | 95 +++++++++
 tb/tb_regfile_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the parametrised register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   XZR_IDX                 : hardwired-zero register index for the default index width
//   reg_idx_t               : register index type at the default index width
package regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int XZR_IDX    = (2 ** ADDR_W_DEF) - 1;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One pending bit per register. A reserve sets the bit, a write releases it;
// when both target the same register in one cycle the reserve wins because it
// belongs to a newer producer. The zero register never becomes pending.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset (clears all bits)
//   reserve       : set pending[reserve_idx] at the edge
//   reserve_idx   : register being reserved
//   release_en    : clear pending[release_idx] at the edge
//   release_idx   : register being released
//   pending       : pending vector, one bit per register
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = XZR_IDX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reserve,
    input  logic [ADDR_W-1:0]      reserve_idx,
    input  logic                   release_en,
    input  logic [ADDR_W-1:0]      release_idx,
    output logic [2**ADDR_W-1:0]   pending
);

    localparam int DEPTH = 2 ** ADDR_W;

    for (genvar r = 0; r < DEPTH; r++) begin : g_bit
        if (r == ZERO_REG) begin : g_zero
            assign pending[r] = 1'b0;
        end else begin : g_flop
            logic set_hit;
            logic clr_hit;
            logic pend_q;

            assign set_hit = reserve    && (reserve_idx == ADDR_W'(r));
            assign clr_hit = release_en && (release_idx == ADDR_W'(r));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_q <= 1'b0;
                end else if (set_hit) begin
                    pend_q <= 1'b1;
                end else if (clr_hit) begin
                    pend_q <= 1'b0;
                end
            end

            assign pending[r] = pend_q;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param
// Multi-read-port register file with a hardwired zero register and a
// pending-write scoreboard for read-after-write hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write
// forwarding to the read ports (data forwarded, busy suppressed).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   RegWrite        : write enable
//   WriteRegister   : write index
//   WriteData       : write data
//   Reserve         : mark ReserveRegister pending
//   ReserveRegister : index to reserve
//   ReadRegister    : NUM_READ read indices
//   ReadData        : NUM_READ read data words (combinational)
//   ReadBusy        : NUM_READ pending flags for the addressed registers
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = (2 ** ADDR_W) - 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               RegWrite,
    input  logic [ADDR_W-1:0]                  WriteRegister,
    input  logic [DATA_W-1:0]                  WriteData,
    input  logic                               Reserve,
    input  logic [ADDR_W-1:0]                  ReserveRegister,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]    ReadRegister,
    output logic [NUM_READ-1:0][DATA_W-1:0]    ReadData,
    output logic [NUM_READ-1:0]                ReadBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  pending;

    // Storage with per-register write decode; the zero register has no flops.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            assign rf_q[r] = '0;
        end else begin : g_store
            logic              we;
            logic [DATA_W-1:0] q;

            assign we = RegWrite && (WriteRegister == ADDR_W'(r));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else if (we) begin
                    q <= WriteData;
                end
            end

            assign rf_q[r] = q;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .reserve     (Reserve),
        .reserve_idx (ReserveRegister),
        .release_en  (RegWrite),
        .release_idx (WriteRegister),
        .pending     (pending)
    );

    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            ReadData[p] = rf_q[ReadRegister[p]];
            ReadBusy[p] = pending[ReadRegister[p]];
`ifdef REGFILE_BYPASS_EN
            // Forwarding is held off during reset so outputs read zero
            // even if a write is presented in the reset cycle.
            if (!reset && RegWrite && (WriteRegister == ReadRegister[p])) begin
                ReadData[p] = WriteData;
                ReadBusy[p] = 1'b0;
            end
`endif
            if (ReadRegister[p] == ADDR_W'(ZERO_REG)) begin
                ReadData[p] = '0;
                ReadBusy[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default configuration: 64-bit, 32 regs, 2 read ports
    logic                 rw;
    reg_idx_t             wr;
    logic [63:0]          wd;
    logic                 rsv;
    reg_idx_t             rsv_r;
    logic [1:0][4:0]      rr;
    logic [1:0][63:0]     rd;
    logic [1:0]           rb;

    // swept configuration: 32-bit, 16 regs, 3 read ports
    logic                 rw1;
    logic [3:0]           wr1;
    logic [31:0]          wd1;
    logic                 rsv1;
    logic [3:0]           rsv_r1;
    logic [2:0][3:0]      rr1;
    logic [2:0][31:0]     rd1;
    logic [2:0]           rb1;

    regfile_param u_dut (
        .clk             (clk),
        .reset           (reset),
        .RegWrite        (rw),
        .WriteRegister   (wr),
        .WriteData       (wd),
        .Reserve         (rsv),
        .ReserveRegister (rsv_r),
        .ReadRegister    (rr),
        .ReadData        (rd),
        .ReadBusy        (rb)
    );

    regfile_param #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .NUM_READ (3)
    ) u_dut_sweep (
        .clk             (clk),
        .reset           (reset),
        .RegWrite        (rw1),
        .WriteRegister   (wr1),
        .WriteData       (wd1),
        .Reserve         (rsv1),
        .ReserveRegister (rsv_r1),
        .ReadRegister    (rr1),
        .ReadData        (rd1),
        .ReadBusy        (rb1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] wi, input logic [63:0] wdat,
                         input logic r, input logic [4:0] ri, input logic [4:0] r0, input logic [4:0] r1);
        rw = w; wr = wi; wd = wdat; rsv = r; rsv_r = ri; rr[0] = r0; rr[1] = r1;
    endtask

    task automatic chk_ports(input string name, input logic [63:0] d0, input logic b0,
                             input logic [63:0] d1, input logic b1);
        chk({name, " d0"}, rd[0], d0);
        chk({name, " b0"}, {63'd0, rb[0]}, {63'd0, b0});
        chk({name, " d1"}, rd[1], d1);
        chk({name, " b1"}, {63'd0, rb[1]}, {63'd0, b1});
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  wi;
        logic [63:0] wdat;
        logic        r;
        logic [4:0]  ri;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        b0;
        logic        b1;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [4:0] wi, input logic [63:0] wdat,
                                input logic r, input logic [4:0] ri,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [63:0] d0, input logic b0,
                                input logic [63:0] d1, input logic b1);
        vec_t v;
        v.w = w; v.wi = wi; v.wdat = wdat; v.r = r; v.ri = ri; v.r0 = r0; v.r1 = r1;
        v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1;
        return v;
    endfunction

    localparam logic [63:0] V7 = 64'h1234_5678_9ABC_DEF0;

    vec_t tv[20];

    logic [31:0] m_reg [16];
    logic        m_pend [16];

    initial begin
        // Expected outputs are those visible before the edge of the row's cycle.
        tv[0]  = mk(0, 0,  0,                     0, 0,  0,  31, 0, 0, 0, 0);
        tv[1]  = mk(1, 7,  V7,                    0, 0,  7,  7,  BYP ? V7 : 64'h0, 0, BYP ? V7 : 64'h0, 0);
        tv[2]  = mk(0, 0,  0,                     0, 0,  7,  7,  V7, 0, V7, 0);
        tv[3]  = mk(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 31, 7,  0, 0, V7, 0);
        tv[4]  = mk(0, 0,  0,                     1, 5,  31, 5,  0, 0, 0, 0);
        tv[5]  = mk(0, 0,  0,                     0, 0,  5,  31, 0, 1, 0, 0);
        tv[6]  = mk(1, 5,  64'h42,                0, 0,  5,  7,  BYP ? 64'h42 : 64'h0, !BYP, V7, 0);
        tv[7]  = mk(0, 0,  0,                     0, 0,  5,  5,  64'h42, 0, 64'h42, 0);
        tv[8]  = mk(0, 0,  0,                     1, 9,  9,  31, 0, 0, 0, 0);
        tv[9]  = mk(1, 9,  64'h11,                1, 9,  9,  9,  BYP ? 64'h11 : 64'h0, !BYP, BYP ? 64'h11 : 64'h0, !BYP);
        tv[10] = mk(0, 0,  0,                     0, 0,  9,  9,  64'h11, 1, 64'h11, 1);
        tv[11] = mk(0, 0,  0,                     1, 31, 31, 9,  0, 0, 64'h11, 1);
        tv[12] = mk(0, 0,  0,                     0, 0,  31, 9,  0, 0, 64'h11, 1);
        tv[13] = mk(1, 9,  64'h22,                1, 10, 9,  10, BYP ? 64'h22 : 64'h11, !BYP, 0, 0);
        tv[14] = mk(0, 0,  0,                     0, 0,  9,  10, 64'h22, 0, 0, 1);
        tv[15] = mk(1, 11, 64'h33,                0, 0,  11, 10, BYP ? 64'h33 : 64'h0, 0, 0, 1);
        tv[16] = mk(0, 0,  0,                     0, 0,  11, 10, 64'h33, 0, 0, 1);
        tv[17] = mk(0, 0,  0,                     1, 10, 10, 10, 0, 1, 0, 1);
        tv[18] = mk(1, 10, 64'h44,                0, 0,  10, 31, BYP ? 64'h44 : 64'h0, !BYP, 0, 0);
        tv[19] = mk(0, 0,  0,                     0, 0,  10, 10, 64'h44, 0, 64'h44, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        rw1 = 0; wr1 = 0; wd1 = 0; rsv1 = 0; rsv_r1 = 0; rr1 = '0;
        #1;
        chk_ports("reset_in", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_ports("reset_out", 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].w, tv[i].wi, tv[i].wdat, tv[i].r, tv[i].ri, tv[i].r0, tv[i].r1);
            #1;
            chk_ports($sformatf("vec%0d", i), tv[i].d0, tv[i].b0, tv[i].d1, tv[i].b1);
            tick();
        end

        // Same-cycle write/read of X2 with an outstanding reservation.
        drive(1, 2, 64'h55, 0, 0, 2, 31); tick();
        drive(0, 0, 0, 1, 2, 2, 31);      tick();
        drive(1, 2, 64'hAB, 0, 0, 2, 2);
        #1;
        chk_ports("bypass_same", BYP ? 64'hAB : 64'h55, !BYP, BYP ? 64'hAB : 64'h55, !BYP);
        tick();
        drive(0, 0, 0, 0, 0, 2, 31);
        #1;
        chk_ports("bypass_next", 64'hAB, 0, 0, 0);

        // Mid-stream reset with a write and reserve presented in the reset cycle.
        drive(1, 3, 64'hDEAD, 0, 0, 3, 3); tick();
        drive(0, 0, 0, 1, 3, 3, 3);
        #1;
        chk_ports("pre_rst_a", 64'hDEAD, 0, 64'hDEAD, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 3);
        #1;
        chk_ports("pre_rst_b", 64'hDEAD, 1, 64'hDEAD, 1);
        drive(1, 3, 64'h99, 1, 4, 3, 7);
        reset = 1'b1;
        #1;
        chk_ports("mid_rst", 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 3, 4);
        #1;
        chk_ports("post_rst_a", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 7, 9);
        #1;
        chk_ports("post_rst_b", 0, 0, 0, 0);

        // Swept configuration against a behavioural model.
        for (int r = 0; r < 16; r++) begin
            m_reg[r] = '0;
            m_pend[r] = 1'b0;
        end
        rw1 = 1; wr1 = 4'd15; wd1 = 32'hFFFF_FFFF; rr1 = {4'd15, 4'd15, 4'd15};
        tick();
        rw1 = 0;
        #1;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("sweep_x15 p%0d d", p), {32'd0, rd1[p]}, 64'd0);
            chk($sformatf("sweep_x15 p%0d b", p), {63'd0, rb1[p]}, 64'd0);
        end
        for (int i = 0; i < 300; i++) begin
            rw1    = ($urandom_range(0, 2) != 0);
            wr1    = 4'($urandom_range(0, 15));
            wd1    = $urandom;
            rsv1   = ($urandom_range(0, 1) != 0);
            rsv_r1 = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) rr1[p] = (p == 0) ? wr1 : 4'($urandom_range(0, 15));
            #1;
            for (int p = 0; p < 3; p++) begin
                logic [31:0] ed;
                logic        eb;
                if (rr1[p] == 4'd15) begin
                    ed = '0; eb = 1'b0;
                end else if (BYP && rw1 && wr1 == rr1[p]) begin
                    ed = wd1; eb = 1'b0;
                end else begin
                    ed = m_reg[rr1[p]]; eb = m_pend[rr1[p]];
                end
                chk($sformatf("rnd%0d p%0d d", i, p), {32'd0, rd1[p]}, {32'd0, ed});
                chk($sformatf("rnd%0d p%0d b", i, p), {63'd0, rb1[p]}, {63'd0, eb});
            end
            tick();
            if (rw1) begin
                if (wr1 != 4'd15) m_reg[wr1] = wd1;
                m_pend[wr1] = 1'b0;
            end
            if (rsv1 && rsv_r1 != 4'd15) m_pend[rsv_r1] = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
